ram_arbiter: RTL and testbench

Two-requester controller for the team's 32×32-bit synchronous single-port RAM. It arbitrates port 0 and port 1 round-robin and drives the RAM's write-enable, address and write data. It returns read data to the winning port with a registered valid flag and supports locked bursts. It sits between two datapath masters (e.g. fetch and load/store) and one RAM instance.

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/ram_arbiter_if.sv | 45 ++++
 rtl/ram_arbiter_rr_arb2.sv | 75 +++++++
 rtl/ram_arbiter.sv | 135 +++++++++++++
 tb/tb_ram_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the two-port RAM arbiter.
//   - arb_state_e : FSM encoding (free arbitration / locked to port 0 / locked to port 1)
//   - AW_DEF, DW_DEF, DEPTH_DEF : default address width, data width, implemented words
//   - PORT0, PORT1 : port index constants used to select bits of two-bit vectors
package ram_arb_pkg;

    localparam int AW_DEF    = 6;
    localparam int DW_DEF    = 32;
    localparam int DEPTH_DEF = 32;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundle of the two requester ports and the RAM-side bus.
//   Requester k : reqk, wek, lockk, addrk, wdatak -> arbiter; gntk, rvalidk, errk <- arbiter
//   Shared      : rdata <- arbiter
//   RAM side    : ram_writeOn, ram_address, ram_data_in <- arbiter; ram_data_out -> arbiter
// Modport slave is the arbiter's view; master is the view of everything around it.
interface ram_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic          lock0;
    logic          lock1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;
    logic          err0;
    logic          err1;
    logic          ram_writeOn;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
        input  ram_data_out,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, err0, err1,
        output ram_writeOn, ram_address, ram_data_in
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
        output ram_data_out,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, err0, err1,
        input  ram_writeOn, ram_address, ram_data_in
    );
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: two-request round-robin picker.
//   clk, rst : clock and synchronous active-high reset
//   req      : request per port
//   lock     : lock request per port (only used to detect the end of a locked burst)
//   state    : arbiter FSM state; a LOCKk state overrides round-robin in favour of port k
//   gnt      : one-hot (or zero) grant, gated off while rst is high
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    input  arb_state_e state,
    output logic [1:0] gnt
);

    logic prio_r;   // port favoured when both request in ARB

    // Grant selection: round-robin in ARB, owner-only while locked.
    always_comb begin
        gnt = 2'b00;
        if (rst) begin
            gnt = 2'b00;
        end else begin
            case (state)
                ARB: begin
                    if (req == 2'b11) begin
                        gnt = prio_r ? 2'b10 : 2'b01;
                    end else begin
                        gnt = req;
                    end
                end
                LOCK0:   gnt = {1'b0, req[PORT0]};
                LOCK1:   gnt = {req[PORT1], 1'b0};
                default: gnt = 2'b00;
            endcase
        end
    end

    // Priority register: hand priority to the other port after an ARB grant or a lock release.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_r <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    if (gnt[PORT0]) begin
                        prio_r <= PORT1;
                    end else if (gnt[PORT1]) begin
                        prio_r <= PORT0;
                    end else begin
                        prio_r <= prio_r;
                    end
                end
                LOCK0: begin
                    if (!req[PORT0] || !lock[PORT0]) begin
                        prio_r <= PORT1;
                    end else begin
                        prio_r <= prio_r;
                    end
                end
                LOCK1: begin
                    if (!req[PORT1] || !lock[PORT1]) begin
                        prio_r <= PORT0;
                    end else begin
                        prio_r <= prio_r;
                    end
                end
                default: prio_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester controller for a synchronous single-port RAM.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : ram_arbiter_if.slave carrying both requester ports and the RAM bus
// Grants are combinational (the RAM samples address/data on the same edge); read
// valid, error pulses and the out-of-range read flag are registered one cycle later.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    arb_state_e state_r;
    arb_state_e state_nxt;
    logic [1:0] gnt;
    logic       oor0;
    logic       oor1;
    logic [1:0] rvalid_r;
    logic [1:0] err_r;
    logic       rd_oor_r;   // the read now being returned was out of range
    logic       rvalid_any;

    assign oor0 = ({1'b0, bus.addr0} >= DEPTH_W);
    assign oor1 = ({1'b0, bus.addr1} >= DEPTH_W);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .req   ({bus.req1, bus.req0}),
        .lock  ({bus.lock1, bus.lock0}),
        .state (state_r),
        .gnt   (gnt)
    );

    assign bus.gnt0 = gnt[PORT0];
    assign bus.gnt1 = gnt[PORT1];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB;
        end else begin
            state_r <= state_nxt;
        end
    end

    // FSM next state: enter a lock on a locked grant, leave it when the owner stops requesting or locking.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ARB: begin
                if (gnt[PORT0] && bus.lock0) begin
                    state_nxt = LOCK0;
                end else if (gnt[PORT1] && bus.lock1) begin
                    state_nxt = LOCK1;
                end else begin
                    state_nxt = ARB;
                end
            end
            LOCK0: begin
                if (!bus.req0 || !bus.lock0) begin
                    state_nxt = ARB;
                end else begin
                    state_nxt = LOCK0;
                end
            end
            LOCK1: begin
                if (!bus.req1 || !bus.lock1) begin
                    state_nxt = ARB;
                end else begin
                    state_nxt = LOCK1;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // FSM outputs: RAM mux; out-of-range writes never reach the RAM.
    always_comb begin
        bus.ram_writeOn = 1'b0;
        bus.ram_address = {AW{1'b0}};
        bus.ram_data_in = {DW{1'b0}};
        if (gnt[PORT0]) begin
            bus.ram_writeOn = bus.we0 && !oor0;
            bus.ram_address = bus.addr0;
            bus.ram_data_in = bus.wdata0;
        end else if (gnt[PORT1]) begin
            bus.ram_writeOn = bus.we1 && !oor1;
            bus.ram_address = bus.addr1;
            bus.ram_data_in = bus.wdata1;
        end else begin
            bus.ram_writeOn = 1'b0;
            bus.ram_address = {AW{1'b0}};
            bus.ram_data_in = {DW{1'b0}};
        end
    end

    // Response pipeline: read valid, error pulse and out-of-range read flag, one cycle after the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_r <= 2'b00;
            err_r    <= 2'b00;
            rd_oor_r <= 1'b0;
        end else begin
            rvalid_r <= {gnt[PORT1] && !bus.we1, gnt[PORT0] && !bus.we0};
            err_r    <= {gnt[PORT1] && oor1, gnt[PORT0] && oor0};
            rd_oor_r <= (gnt[PORT0] && !bus.we0 && oor0) || (gnt[PORT1] && !bus.we1 && oor1);
        end
    end

    // A response registered just before reset rises is dropped while rst is high.
    assign bus.rvalid0 = rvalid_r[PORT0] && !rst;
    assign bus.rvalid1 = rvalid_r[PORT1] && !rst;
    assign bus.err0    = err_r[PORT0] && !rst;
    assign bus.err1    = err_r[PORT1] && !rst;
    assign rvalid_any  = bus.rvalid0 || bus.rvalid1;

    // Shared read data: RAM output only for a valid in-range read, zero otherwise.
    always_comb begin
        bus.rdata = {DW{1'b0}};
        if (rvalid_any && !rd_oor_r) begin
            bus.rdata = bus.ram_data_out;
        end else begin
            bus.rdata = {DW{1'b0}};
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: table-driven directed vectors, a hand-written reset-during-lock
// sequence, then randomized traffic checked against a behavioural reference model.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ram_arbiter_if #(.AW(6), .DW(32)) bus ();

    ram_arbiter #(.AW(6), .DW(32), .DEPTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: 64 words so any 6-bit address is legal; write-before-read on the edge.
    logic [31:0] ram_mem [64];
    always @(posedge clk) begin
        if (bus.ram_writeOn) begin
            ram_mem[bus.ram_address] <= bus.ram_data_in;
            bus.ram_data_out         <= bus.ram_data_in;
        end else begin
            bus.ram_data_out <= ram_mem[bus.ram_address];
        end
    end

    typedef struct packed {
        logic        rst;
        logic        r0, w0, l0;
        logic [5:0]  a0;
        logic [31:0] d0;
        logic        r1, w1, l1;
        logic [5:0]  a1;
        logic [31:0] d1;
    } in_t;

    typedef struct packed {
        logic        g0, g1, we;
        logic [5:0]  addr;
        logic [31:0] din;
        logic        rv0, rv1;
        logic [31:0] rdata;
        logic        e0, e1;
    } outs_t;

    typedef struct packed {
        in_t   stim;
        outs_t expv;
    } vec_t;

    int vectors_applied = 0;
    int miscompares     = 0;

    // Reference model state: who owns a lock (-1 none), favoured port, pending response.
    int          owner;
    int          fav;
    bit          prv [2];
    bit          perr [2];
    logic [31:0] pdata;
    logic [31:0] mref [32];

    function automatic in_t mkin(input logic rs,
                                 input logic r0, input logic w0, input logic l0,
                                 input logic [5:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input logic l1,
                                 input logic [5:0] a1, input logic [31:0] d1);
        in_t v;
        v.rst = rs; v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        return v;
    endfunction

    function automatic outs_t mkout(input logic g0, input logic g1, input logic we,
                                    input logic [5:0] addr, input logic [31:0] din,
                                    input logic rv0, input logic rv1,
                                    input logic [31:0] rdata,
                                    input logic e0, input logic e1);
        outs_t o;
        o.g0 = g0; o.g1 = g1; o.we = we; o.addr = addr; o.din = din;
        o.rv0 = rv0; o.rv1 = rv1; o.rdata = rdata; o.e0 = e0; o.e1 = e1;
        return o;
    endfunction

    function automatic vec_t mkv(input in_t i, input outs_t o);
        vec_t v;
        v.stim = i;
        v.expv = o;
        return v;
    endfunction

    // One model cycle: returns this cycle's expected outputs and advances the model.
    function automatic outs_t model_step(input in_t v);
        outs_t       e;
        bit          rq [2];
        bit          lk [2];
        bit          wr [2];
        logic [5:0]  ad [2];
        logic [31:0] wd [2];
        int          win;
        bit          inr;
        e = '0;
        rq[0] = v.r0; rq[1] = v.r1;
        lk[0] = v.l0; lk[1] = v.l1;
        wr[0] = v.w0; wr[1] = v.w1;
        ad[0] = v.a0; ad[1] = v.a1;
        wd[0] = v.d0; wd[1] = v.d1;
        win = -1;
        if (!v.rst) begin
            e.rv0   = prv[0];
            e.rv1   = prv[1];
            e.rdata = (prv[0] || prv[1]) ? pdata : 32'd0;
            e.e0    = perr[0];
            e.e1    = perr[1];
            if (owner >= 0) begin
                if (rq[owner]) win = owner;
                if (!rq[owner] || !lk[owner]) begin
                    fav   = 1 - owner;
                    owner = -1;
                end
            end else begin
                if (rq[0] && rq[1]) win = fav;
                else if (rq[0])     win = 0;
                else if (rq[1])     win = 1;
                if (win >= 0) begin
                    fav = 1 - win;
                    if (lk[win]) owner = win;
                end
            end
        end else begin
            owner = -1;
            fav   = 0;
        end
        prv[0] = 1'b0; prv[1] = 1'b0;
        perr[0] = 1'b0; perr[1] = 1'b0;
        if (win >= 0) begin
            inr    = (int'(ad[win]) < 32);
            e.g0   = (win == 0);
            e.g1   = (win == 1);
            e.addr = ad[win];
            e.din  = wd[win];
            e.we   = wr[win] && inr;
            if (wr[win] && inr) mref[ad[win][4:0]] = wd[win];
            if (!wr[win]) begin
                prv[win] = 1'b1;
                pdata    = inr ? mref[ad[win][4:0]] : 32'd0;
            end
            if (!inr) perr[win] = 1'b1;
        end
        return e;
    endfunction

    // Apply one cycle of stimulus, compare mid-cycle, then advance to just after the next edge.
    task automatic run_cycle(input in_t v, input bit use_model, input outs_t tbl_exp,
                             input string name);
        outs_t em;
        outs_t ex;
        outs_t act;
        rst        = v.rst;
        bus.req0   = v.r0; bus.we0 = v.w0; bus.lock0 = v.l0; bus.addr0 = v.a0; bus.wdata0 = v.d0;
        bus.req1   = v.r1; bus.we1 = v.w1; bus.lock1 = v.l1; bus.addr1 = v.a1; bus.wdata1 = v.d1;
        #4;
        em  = model_step(v);
        ex  = use_model ? em : tbl_exp;
        act = mkout(bus.gnt0, bus.gnt1, bus.ram_writeOn, bus.ram_address, bus.ram_data_in,
                    bus.rvalid0, bus.rvalid1, bus.rdata, bus.err0, bus.err1);
        vectors_applied++;
        if (act !== ex) begin
            miscompares++;
            $display("FAIL %s: got g0=%b g1=%b we=%b addr=%0d din=%h rv0=%b rv1=%b rdata=%h e0=%b e1=%b, need g0=%b g1=%b we=%b addr=%0d din=%h rv0=%b rv1=%b rdata=%h e0=%b e1=%b",
                     name, act.g0, act.g1, act.we, act.addr, act.din, act.rv0, act.rv1,
                     act.rdata, act.e0, act.e1, ex.g0, ex.g1, ex.we, ex.addr, ex.din,
                     ex.rv0, ex.rv1, ex.rdata, ex.e0, ex.e1);
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] B7 = 32'h12345678;
    localparam logic [31:0] A1 = 32'hA1A1_0001;
    localparam logic [31:0] A2 = 32'hA2A2_0002;
    localparam logic [31:0] A3 = 32'hA3A3_0003;
    localparam logic [31:0] Z  = 32'd0;

    vec_t tbl [$];

    initial begin
        in_t rv;
        for (int i = 0; i < 64; i++) ram_mem[i] = 32'd0;
        for (int i = 0; i < 32; i++) mref[i] = 32'd0;
        bus.ram_data_out = 32'd0;
        owner = -1; fav = 0; pdata = 32'd0;
        prv[0] = 1'b0; prv[1] = 1'b0; perr[0] = 1'b0; perr[1] = 1'b0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.lock0 = 1'b0; bus.addr0 = 6'd0; bus.wdata0 = 32'd0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0; bus.addr1 = 6'd0; bus.wdata1 = 32'd0;

        //            rst  r0 w0 l0  a0     d0        r1 w1 l1  a1     d1
        tbl.push_back(mkv(mkin(1'b1, 0,0,0, 6'd0,  Z,       0,0,0, 6'd0,  Z ), mkout(0,0,0, 6'd0,  Z,    0,0, Z,  0,0)));
        tbl.push_back(mkv(mkin(1'b1, 1,1,0, 6'd5,  DB,      0,0,0, 6'd0,  Z ), mkout(0,0,0, 6'd0,  Z,    0,0, Z,  0,0)));
        tbl.push_back(mkv(mkin(1'b0, 1,1,0, 6'd5,  DB,      0,0,0, 6'd0,  Z ), mkout(1,0,1, 6'd5,  DB,   0,0, Z,  0,0)));
        tbl.push_back(mkv(mkin(1'b0, 1,0,0, 6'd5,  Z,       0,0,0, 6'd0,  Z ), mkout(1,0,0, 6'd5,  Z,    0,0, Z,  0,0)));
        tbl.push_back(mkv(mkin(1'b0, 0,0,0, 6'd0,  Z,       0,0,0, 6'd0,  Z ), mkout(0,0,0, 6'd0,  Z,    1,0, DB, 0,0)));
        tbl.push_back(mkv(mkin(1'b0, 0,0,0, 6'd0,  Z,       1,1,0, 6'd7,  B7), mkout(0,1,1, 6'd7,  B7,   0,0, Z,  0,0)));
        tbl.push_back(mkv(mkin(1'b0, 1,0,0, 6'd5,  Z,       1,0,0, 6'd7,  Z ), mkout(1,0,0, 6'd5,  Z,    0,0, Z,  0,0)));
        tbl.push_back(mkv(mkin(1'b0, 1,0,0, 6'd5,  Z,       1,0,0, 6'd7,  Z ), mkout(0,1,0, 6'd7,  Z,    1,0, DB, 0,0)));
        tbl.push_back(mkv(mkin(1'b0, 1,0,0, 6'd5,  Z,       1,0,0, 6'd7,  Z ), mkout(1,0,0, 6'd5,  Z,    0,1, B7, 0,0)));
        tbl.push_back(mkv(mkin(1'b0, 1,0,0, 6'd5,  Z,       1,0,0, 6'd7,  Z ), mkout(0,1,0, 6'd7,  Z,    1,0, DB, 0,0)));
        tbl.push_back(mkv(mkin(1'b0, 0,0,0, 6'd0,  Z,       0,0,0, 6'd0,  Z ), mkout(0,0,0, 6'd0,  Z,    0,1, B7, 0,0)));
        tbl.push_back(mkv(mkin(1'b0, 1,0,0, 6'd5,  Z,       0,0,0, 6'd0,  Z ), mkout(1,0,0, 6'd5,  Z,    0,0, Z,  0,0)));
        tbl.push_back(mkv(mkin(1'b0, 1,0,0, 6'd5,  Z,       1,1,1, 6'd8,  A1), mkout(0,1,1, 6'd8,  A1,   1,0, DB, 0,0)));
        tbl.push_back(mkv(mkin(1'b0, 1,0,0, 6'd5,  Z,       1,1,1, 6'd9,  A2), mkout(0,1,1, 6'd9,  A2,   0,0, Z,  0,0)));
        tbl.push_back(mkv(mkin(1'b0, 1,0,0, 6'd5,  Z,       1,1,0, 6'd10, A3), mkout(0,1,1, 6'd10, A3,   0,0, Z,  0,0)));
        tbl.push_back(mkv(mkin(1'b0, 1,0,0, 6'd8,  Z,       1,0,0, 6'd9,  Z ), mkout(1,0,0, 6'd8,  Z,    0,0, Z,  0,0)));
        tbl.push_back(mkv(mkin(1'b0, 0,0,0, 6'd0,  Z,       0,0,0, 6'd0,  Z ), mkout(0,0,0, 6'd0,  Z,    1,0, A1, 0,0)));
        tbl.push_back(mkv(mkin(1'b0, 1,1,0, 6'd40, 32'h55,  0,0,0, 6'd0,  Z ), mkout(1,0,0, 6'd40, 32'h55, 0,0, Z, 0,0)));
        tbl.push_back(mkv(mkin(1'b0, 1,0,0, 6'd63, Z,       0,0,0, 6'd0,  Z ), mkout(1,0,0, 6'd63, Z,    0,0, Z,  1,0)));
        tbl.push_back(mkv(mkin(1'b0, 0,0,0, 6'd0,  Z,       0,0,0, 6'd0,  Z ), mkout(0,0,0, 6'd0,  Z,    1,0, Z,  1,0)));
        tbl.push_back(mkv(mkin(1'b0, 0,0,0, 6'd0,  Z,       0,0,0, 6'd0,  Z ), mkout(0,0,0, 6'd0,  Z,    0,0, Z,  0,0)));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            run_cycle(tbl[i].stim, 1'b0, tbl[i].expv, $sformatf("table[%0d]", i));
        end

        // Reset while locked to port 0 with a read in flight; port 0 must win first afterwards.
        run_cycle(mkin(1'b0, 1,0,1, 6'd5, Z, 0,0,0, 6'd0, Z), 1'b0,
                  mkout(1,0,0, 6'd5, Z, 0,0, Z, 0,0), "lock0_enter");
        run_cycle(mkin(1'b0, 1,0,1, 6'd8, Z, 1,0,0, 6'd7, Z), 1'b0,
                  mkout(1,0,0, 6'd8, Z, 1,0, DB, 0,0), "lock0_hold");
        run_cycle(mkin(1'b1, 1,0,1, 6'd8, Z, 1,0,0, 6'd7, Z), 1'b0,
                  mkout(0,0,0, 6'd0, Z, 0,0, Z, 0,0), "rst_in_lock");
        run_cycle(mkin(1'b0, 1,0,0, 6'd5, Z, 1,0,0, 6'd7, Z), 1'b0,
                  mkout(1,0,0, 6'd5, Z, 0,0, Z, 0,0), "post_rst_prio");
        run_cycle(mkin(1'b0, 0,0,0, 6'd0, Z, 0,0,0, 6'd0, Z), 1'b0,
                  mkout(0,0,0, 6'd0, Z, 1,0, DB, 0,0), "post_rst_read");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            rv.rst = ($urandom_range(0, 49) == 0);
            rv.r0  = ($urandom_range(0, 3) != 0);
            rv.w0  = $urandom_range(0, 1);
            rv.l0  = ($urandom_range(0, 2) == 0);
            rv.a0  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
            rv.d0  = $urandom;
            rv.r1  = ($urandom_range(0, 3) != 0);
            rv.w1  = $urandom_range(0, 1);
            rv.l1  = ($urandom_range(0, 2) == 0);
            rv.a1  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
            rv.d1  = $urandom;
            run_cycle(rv, 1'b1, '0, $sformatf("random[%0d]", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
